// File: rtl/ysyx_22050133_div_pkg.sv
// ysyx_22050133_div_pkg: shared encodings, FSM states and helpers for the divide issue path
package ysyx_22050133_div_pkg;
  localparam int XLEN = 64;
  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, DONE = 2'd3} div_issue_state_t;
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
endpackage

// File: rtl/ysyx_22050133_div_special.sv
// ysyx_22050133_div_special: detects divide-by-zero and signed overflow and forms their results
module ysyx_22050133_div_special
  import ysyx_22050133_div_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] special_result_o
);
  logic is_signed, is_rem, dz, ovf;
  logic [XLEN-1:0] raw;
  assign is_signed = (op_i == DIV_OP_DIV) | (op_i == DIV_OP_REM);
  assign is_rem    = op_i[1];
  assign dz  = word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
  assign ovf = is_signed & (word_i ? (src1_i[31:0] == 32'h8000_0000) & (src2_i[31:0] == 32'hFFFF_FFFF)
                                   : (src1_i == {1'b1, {(XLEN-1){1'b0}}}) & (src2_i == '1));
  assign raw = dz ? (is_rem ? src1_i : '1) : (is_rem ? '0 : src1_i);
  assign is_special_o     = dz | ovf;
  assign special_result_o = sext_w(raw, word_i);
endmodule

// File: rtl/ysyx_22050133_div_issue.sv
// ysyx_22050133_div_issue: issues M-extension divides to the divider and holds the writeback result
module ysyx_22050133_div_issue
  import ysyx_22050133_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            div_valid,
  output logic            div_divw,
  output logic            div_signed,
  output logic            div_flush,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);
  div_issue_state_t state_q, state_d;
  logic [1:0] op_q;
  logic word_q, signed_q, accept, is_special;
  logic [XLEN-1:0] src1_q, src2_q, res_q, special_result;
  ysyx_22050133_div_special u_special (
    .op_i             (req_op),
    .word_i           (req_word),
    .src1_i           (req_src1),
    .src2_i           (req_src2),
    .is_special_o     (is_special),
    .special_result_o (special_result)
  );
  assign accept  = req_valid & req_ready & ~flush;
  assign state_d = flush              ? IDLE :
                   (state_q == IDLE)   ? (req_valid ? (is_special ? DONE : LAUNCH) : IDLE) :
                   (state_q == LAUNCH) ? (div_ready ? WAIT : LAUNCH) :
                   (state_q == WAIT)   ? (div_out_valid ? DONE : WAIT) :
                                         (resp_ready ? IDLE : DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_op;
        word_q   <= req_word;
        signed_q <= ~req_op[0];
        src1_q   <= req_src1;
        src2_q   <= req_src2;
        if (is_special) res_q <= special_result;
      end else if ((state_q == WAIT) & div_out_valid & ~flush) begin
        res_q <= sext_w(op_q[1] ? div_remainder : div_quotient, word_q);
      end
    end
  end
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign resp_data    = res_q;
  assign div_valid    = (state_q == LAUNCH);
  assign div_divw     = word_q;
  assign div_signed   = signed_q;
  assign div_flush    = flush;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;
endmodule

// File: tb/tb_ysyx_22050133_div_issue.sv
// tb_ysyx_22050133_div_issue: directed checks of the divide issue controller against a behavioural divider
module tb_ysyx_22050133_div_issue;
  import ysyx_22050133_div_pkg::*;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic req_valid = 1'b0, req_ready, req_word = 1'b0, resp_valid, resp_ready = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [63:0] req_src1 = '0, req_src2 = '0, resp_data;
  logic div_valid, div_divw, div_signed, div_flush, div_ready, div_out_valid;
  logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;
  int n_tests = 0, n_fail = 0;
  logic div_seen = 1'b0, flush_seen = 1'b0;
  always #5 clk = ~clk;
  ysyx_22050133_div_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_valid(div_valid), .div_divw(div_divw), .div_signed(div_signed), .div_flush(div_flush),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_out_valid(div_out_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );
  logic m_busy, m_en, m_sgn, m_w;
  logic [63:0] m_a, m_b;
  int m_cnt;
  function automatic logic [127:0] div_calc(logic sgn, logic w, logic [63:0] a, logic [63:0] b);
    logic [63:0] q, r;
    if (w && sgn) begin
      q = 64'($signed(a[31:0]) / $signed(b[31:0]));
      r = 64'($signed(a[31:0]) % $signed(b[31:0]));
    end else if (w) begin
      q = {32'b0, a[31:0] / b[31:0]};
      r = {32'b0, a[31:0] % b[31:0]};
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_en <= 1'b0; m_cnt <= 0; div_out_valid <= 1'b0;
      m_sgn <= 1'b0; m_w <= 1'b0; m_a <= '0; m_b <= '0;
      div_quotient <= '0; div_remainder <= '0;
    end else if (div_flush) begin
      m_busy <= 1'b0; m_en <= 1'b1; div_out_valid <= 1'b0;
    end else begin
      m_en <= 1'b1;
      if (div_valid && div_ready) begin
        m_busy <= 1'b1; div_out_valid <= 1'b0;
        m_cnt <= div_divw ? 33 : 65;
        m_sgn <= div_signed; m_w <= div_divw; m_a <= div_dividend; m_b <= div_divisor;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0; div_out_valid <= 1'b1;
          {div_quotient, div_remainder} <= div_calc(m_sgn, m_w, m_a, m_b);
        end
      end
    end
  end
  assign div_ready = m_en & ~m_busy;
  always @(negedge clk) begin
    if (div_valid) div_seen <= 1'b1;
    if (div_flush) flush_seen <= 1'b1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    div_seen = 1'b0;
    req_op = op; req_word = w; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_resp(output logic [63:0] d, output int lat);
    lat = 1;
    while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
    if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
    d = resp_data;
  endtask
  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     output logic [63:0] d, output int lat);
    issue(op, w, a, b);
    wait_resp(d, lat);
    handshake();
  endtask
  logic [63:0] d, held;
  int lat;
  logic stable;
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_div_ctrl", {60'b0, div_valid, div_divw, div_signed, div_flush}, 64'd0);
    check("rst_div_operands", div_dividend | div_divisor, 64'd0);
    run(DIV_OP_DIV, 1'b0, -64'sd7, 64'd2, d, lat);
    check("div_data", d, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_lat", 64'(lat >= 30), 64'd1);
    run(DIV_OP_REM, 1'b0, -64'sd7, 64'd2, d, lat);
    check("rem_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rem_lat", 64'(lat >= 30), 64'd1);
    run(DIV_OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, d, lat);
    check("divuw_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
    run(DIV_OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, d, lat);
    check("divw_data", d, 64'hFFFF_FFFF_FFFF_FFFD);
    run(DIV_OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, d, lat);
    check("remw_dz_data", d, 64'hFFFF_FFFF_8000_0000);
    check("remw_dz_lat", 64'(lat), 64'd1);
    run(DIV_OP_DIVU, 1'b0, 64'd5, 64'd0, d, lat);
    check("divu_dz_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divu_dz_lat", 64'(lat), 64'd1);
    check("divu_dz_no_launch", 64'(div_seen), 64'd0);
    run(DIV_OP_REMU, 1'b0, 64'd5, 64'd0, d, lat);
    check("remu_dz_data", d, 64'd5);
    run(DIV_OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, d, lat);
    check("div_ovf_data", d, 64'h8000_0000_0000_0000);
    check("div_ovf_lat", 64'(lat), 64'd1);
    check("div_ovf_no_launch", 64'(div_seen), 64'd0);
    run(DIV_OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, d, lat);
    check("rem_ovf_data", d, 64'd0);
    run(DIV_OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, d, lat);
    check("divw_ovf_data", d, 64'hFFFF_FFFF_8000_0000);
    // flush and request in the same cycle must not be accepted
    req_op = DIV_OP_DIVU; req_word = 1'b0; req_src1 = 64'd9; req_src2 = 64'd3;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_not_taken", {62'b0, req_ready, resp_valid}, 64'd2);
    issue(DIV_OP_DIVU, 1'b0, 64'd1000, 64'd7);
    lat = 0;
    while (!(dut.state_q == WAIT) && lat < 50) begin @(negedge clk); lat++; end
    check("reach_wait", 64'(dut.state_q), 64'(WAIT));
    repeat (10) @(negedge clk);
    flush_seen = 1'b0;
    flush = 1'b1;
    #1 check("div_flush_comb", 64'(div_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'(dut.state_q), 64'(IDLE));
    check("flush_resp_valid", 64'(resp_valid), 64'd0);
    check("flush_pulse", 64'(flush_seen), 64'd1);
    run(DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, d, lat);
    check("post_flush_divu", d, 64'd14);
    issue(DIV_OP_DIVU, 1'b0, 64'd100, 64'd7);
    wait_resp(held, lat);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_data !== held || !resp_valid || req_ready) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_data", resp_data, 64'd14);
    handshake();
    check("bp_release_ready", {62'b0, req_ready, resp_valid}, 64'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
